// File: rtl/fifo_pkt_pkg.sv
// Shared types and constants for the FIFO packetizer: FSM state encoding and
// the default header byte.
package fifo_pkt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CSUM    = 2'd3
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/pkt_out_stage.sv
// Single output holding register for the packet stream. Handshake: a byte
// moves on every rclk edge where m_valid and m_ready are both high.
module pkt_out_stage (
    input  logic       rclk,
    input  logic       rrst_n,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       load_sop,
    input  logic       load_eop,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_sop,
    output logic       m_eop,
    output logic       free
);

    logic take;

    // The register may be overwritten when empty or when its byte leaves now.
    assign free = !m_valid || m_ready;
    assign take = load && free;

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            m_data  <= 8'h00;
            m_valid <= 1'b0;
            m_sop   <= 1'b0;
            m_eop   <= 1'b0;
        end else if (take) begin
            m_data  <= load_data;
            m_valid <= 1'b1;
            m_sop   <= load_sop;
            m_eop   <= load_eop;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_packetizer.sv
// Reads payload bytes from a first-word-fall-through FIFO and frames them as
// SYNC, LEN, payload, checksum onto a valid/ready byte stream.
module fifo_packetizer
    import fifo_pkt_pkg::*;
#(
    parameter int         PKT_LEN   = 4,
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic        rclk,
    input  logic        rrst_n,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_rdata,
    output logic        fifo_r_en,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_sop,
    output logic        m_eop,
    output logic [15:0] pkt_count,
    output logic [1:0]  dbg_state
);

    localparam logic [7:0] LEN_BYTE = 8'(PKT_LEN);
    localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

    state_t      state;
    logic [7:0]  csum;
    logic [7:0]  byte_cnt;
    logic [15:0] pkt_count_q;

    logic        free;
    logic        load;
    logic        pop;
    logic [7:0]  ld_data;
    logic        ld_sop;
    logic        ld_eop;

    always_comb begin
        load    = 1'b0;
        pop     = 1'b0;
        ld_data = 8'h00;
        ld_sop  = 1'b0;
        ld_eop  = 1'b0;
        case (state)
            ST_IDLE: begin
                load    = free && !fifo_empty;
                ld_data = SYNC_BYTE;
                ld_sop  = 1'b1;
            end
            ST_LEN: begin
                load    = free;
                ld_data = LEN_BYTE;
            end
            ST_PAYLOAD: begin
                // A pop and a load are the same event: no pop without a free slot.
                pop     = free && !fifo_empty && rrst_n;
                load    = pop;
                ld_data = fifo_rdata;
            end
            ST_CSUM: begin
                load    = free;
                ld_data = csum;
                ld_eop  = 1'b1;
            end
            default: ;
        endcase
    end

    assign fifo_r_en = pop;
    assign pkt_count = pkt_count_q;
    assign dbg_state = state;

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            state       <= ST_IDLE;
            csum        <= 8'h00;
            byte_cnt    <= 8'h00;
            pkt_count_q <= 16'h0000;
        end else begin
            if (m_valid && m_ready && m_eop)
                pkt_count_q <= pkt_count_q + 16'd1;
            case (state)
                ST_IDLE: if (load) begin
                    csum     <= 8'h00;
                    byte_cnt <= 8'h00;
                    state    <= ST_LEN;
                end
                ST_LEN: if (load) state <= ST_PAYLOAD;
                ST_PAYLOAD: if (pop) begin
                    csum     <= csum + fifo_rdata;
                    byte_cnt <= byte_cnt + 8'd1;
                    if (byte_cnt == LAST_IDX)
                        state <= ST_CSUM;
                end
                ST_CSUM: if (load) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    pkt_out_stage u_out (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .load      (load),
        .load_data (ld_data),
        .load_sop  (ld_sop),
        .load_eop  (ld_eop),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_sop     (m_sop),
        .m_eop     (m_eop),
        .free      (free)
    );

endmodule

// File: tb/tb_fifo_packetizer.sv
// Directed bench for fifo_packetizer: a PKT_LEN=4 instance for framing, stall,
// gap, back-to-back and reset cases, and a PKT_LEN=1 instance for the count wrap.
module tb_fifo_packetizer;

    logic rclk = 1'b0;
    always #5 rclk = ~rclk;

    logic        rrst_n;
    logic        fifo_empty0, fifo_empty1;
    logic [7:0]  fifo_rdata0, fifo_rdata1;
    logic        fifo_r_en0, fifo_r_en1;
    logic [7:0]  m_data0, m_data1;
    logic        m_valid0, m_valid1;
    logic        m_ready0, m_ready1;
    logic        m_sop0, m_sop1, m_eop0, m_eop1;
    logic [15:0] pkt_count0, pkt_count1;
    logic [1:0]  dbg_state0, dbg_state1;

    fifo_packetizer #(.PKT_LEN(4), .SYNC_BYTE(8'hA5)) u_dut0 (
        .rclk(rclk), .rrst_n(rrst_n), .fifo_empty(fifo_empty0), .fifo_rdata(fifo_rdata0),
        .fifo_r_en(fifo_r_en0), .m_data(m_data0), .m_valid(m_valid0), .m_ready(m_ready0),
        .m_sop(m_sop0), .m_eop(m_eop0), .pkt_count(pkt_count0), .dbg_state(dbg_state0)
    );

    fifo_packetizer #(.PKT_LEN(1), .SYNC_BYTE(8'hA5)) u_dut1 (
        .rclk(rclk), .rrst_n(rrst_n), .fifo_empty(fifo_empty1), .fifo_rdata(fifo_rdata1),
        .fifo_r_en(fifo_r_en1), .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready1),
        .m_sop(m_sop1), .m_eop(m_eop1), .pkt_count(pkt_count1), .dbg_state(dbg_state1)
    );

    // FWFT FIFO models: pop on the edge, present the new head at the falling edge.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         cyc = 0;

    always @(posedge rclk) begin
        cyc <= cyc + 1;
        if (fifo_r_en0 && q0.size() != 0) void'(q0.pop_front());
        if (fifo_r_en1 && q1.size() != 0) void'(q1.pop_front());
    end

    // Scoreboard capture: {sop, eop, data} of every byte that will be accepted.
    logic [9:0] got_q[$];
    int         got_t[$];
    logic [9:0] got1_q[$];
    logic [9:0] exp_q[$];

    always @(negedge rclk) begin
        fifo_empty0 = (q0.size() == 0);
        fifo_rdata0 = (q0.size() != 0) ? q0[0] : 8'h00;
        fifo_empty1 = (q1.size() == 0);
        fifo_rdata1 = (q1.size() != 0) ? q1[0] : 8'h00;
        if (m_valid0 && m_ready0) begin
            got_q.push_back({m_sop0, m_eop0, m_data0});
            got_t.push_back(cyc);
        end
        if (m_valid1 && m_ready1)
            got1_q.push_back({m_sop1, m_eop1, m_data1});
    end

    int n_pass   = 0;
    int n_checks = 0;
    int first_t, last_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge rclk);
            #1;
        end
    endtask

    // Wait for the expected byte count on one stream, then compare byte by byte.
    task automatic drain(input string tag, input bit which);
        int n;
        int k;
        int have;
        n = exp_q.size();
        k = 0;
        have = which ? got1_q.size() : got_q.size();
        while (have < n && k < 80) begin
            @(negedge rclk);
            #1;
            k++;
            have = which ? got1_q.size() : got_q.size();
        end
        check($sformatf("%s_len", tag), have, n);
        for (int i = 0; i < n && i < have; i++)
            check($sformatf("%s_b%0d", tag, i), which ? got1_q[i] : got_q[i], exp_q[i]);
        first_t = (!which && got_t.size() != 0) ? got_t[0] : -1;
        last_t  = (!which && got_t.size() >= n && n > 0) ? got_t[n-1] : -1;
        if (which) got1_q.delete();
        else begin
            got_q.delete();
            got_t.delete();
        end
    endtask

    task automatic push0(input logic [7:0] b);
        q0.push_back(b);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int eops;
        rrst_n      = 1'b0;
        m_ready0    = 1'b1;
        m_ready1    = 1'b1;
        fifo_empty0 = 1'b1;
        fifo_empty1 = 1'b1;
        fifo_rdata0 = 8'h00;
        fifo_rdata1 = 8'h00;
        tick(3);

        check("rst_out0", {m_valid0, m_sop0, m_eop0, m_data0}, 32'h0);
        check("rst_cnt0", pkt_count0, 16'h0000);
        check("rst_ren0", fifo_r_en0, 1'b0);
        check("rst_state", {dbg_state1, dbg_state0}, 4'h0);
        rrst_n = 1'b1;
        tick(2);

        // Basic packet, m_ready held high.
        c = cyc;
        push0(8'h01); push0(8'h02); push0(8'h03); push0(8'h04);
        exp_q = '{10'h2A5, 10'h004, 10'h001, 10'h002, 10'h003, 10'h004, 10'h10A};
        drain("basic", 1'b0);
        check("basic_latency", first_t, c + 1);
        check("basic_span", last_t - first_t, 6);
        tick(2);
        check("basic_cnt", pkt_count0, 16'd1);

        // Downstream stall of 3 cycles while 02 is presented.
        c = cyc;
        push0(8'h01); push0(8'h02); push0(8'h03); push0(8'h04);
        tick(4);
        m_ready0 = 1'b0;
        check("stall_q_before", q0.size(), 2);
        tick(3);
        check("stall_hold", {m_valid0, m_sop0, m_eop0, m_data0}, 32'h402);
        check("stall_q_after", q0.size(), 2);
        m_ready0 = 1'b1;
        drain("stall", 1'b0);
        check("stall_span", last_t - first_t, 9);
        tick(2);
        check("stall_cnt", pkt_count0, 16'd2);

        // FIFO runs dry mid-payload, then refills.
        push0(8'h10); push0(8'h20);
        tick(8);
        check("gap_valid", m_valid0, 1'b0);
        check("gap_q", q0.size(), 0);
        push0(8'h30); push0(8'h40);
        exp_q = '{10'h2A5, 10'h004, 10'h010, 10'h020, 10'h030, 10'h040, 10'h1A0};
        drain("gap", 1'b0);
        tick(2);
        check("gap_cnt", pkt_count0, 16'd3);

        // Two packets back to back from one burst of FF bytes.
        for (int i = 0; i < 8; i++) push0(8'hFF);
        exp_q = '{10'h2A5, 10'h004, 10'h0FF, 10'h0FF, 10'h0FF, 10'h0FF, 10'h1FC,
                  10'h2A5, 10'h004, 10'h0FF, 10'h0FF, 10'h0FF, 10'h0FF, 10'h1FC};
        drain("b2b", 1'b0);
        check("b2b_span", last_t - first_t, 13);
        tick(2);
        check("b2b_cnt", pkt_count0, 16'd5);

        // Reset while byte 02 is presented.
        push0(8'h01); push0(8'h02); push0(8'h03); push0(8'h04);
        tick(4);
        rrst_n = 1'b0;
        tick(2);
        check("mrst_out", {m_valid0, m_sop0, m_eop0, m_data0}, 32'h0);
        check("mrst_cnt", pkt_count0, 16'h0000);
        check("mrst_ren", fifo_r_en0, 1'b0);
        check("mrst_state", dbg_state0, 2'd0);
        check("mrst_seen", got_q.size(), 4);
        eops = 0;
        foreach (got_q[i]) eops += int'(got_q[i][8]);
        check("mrst_no_eop", eops, 0);
        got_q.delete();
        got_t.delete();
        q0.delete();
        tick(1);
        rrst_n = 1'b1;
        tick(1);
        push0(8'h05); push0(8'h06); push0(8'h07); push0(8'h08);
        exp_q = '{10'h2A5, 10'h004, 10'h005, 10'h006, 10'h007, 10'h008, 10'h11A};
        drain("post_rst", 1'b0);
        tick(2);
        check("post_rst_cnt", pkt_count0, 16'd1);

        // PKT_LEN=1 instance: one payload pop per packet.
        q1.push_back(8'h3C);
        exp_q = '{10'h2A5, 10'h001, 10'h03C, 10'h13C};
        drain("len1", 1'b1);
        tick(2);
        check("len1_cnt", pkt_count1, 16'd1);

        // Fast-forward the counter to FFFF instead of streaming 65535 packets.
        force u_dut1.pkt_count_q = 16'hFFFF;
        tick(1);
        release u_dut1.pkt_count_q;
        tick(1);
        q1.push_back(8'h01);
        exp_q = '{10'h2A5, 10'h001, 10'h001, 10'h101};
        drain("wrap", 1'b1);
        tick(2);
        check("wrap_cnt", pkt_count1, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
